// File: rtl/port_in_arbiter_pkg.sv
// rtl/port_in_arbiter_pkg.sv - shared state encoding, source indices and counter width
package port_in_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_READ = 2'd2
    } arb_state_e;

    localparam logic [1:0] SRC_DATA  = 2'd0;
    localparam logic [1:0] SRC_BYTE0 = 2'd1;
    localparam logic [1:0] SRC_BYTE1 = 2'd2;
    localparam logic [1:0] SRC_BCD   = 2'd3;

    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/port_in_rr_picker.sv
// rtl/port_in_rr_picker.sv - combinational round-robin pick starting after the last served source
module port_in_rr_picker
    import port_in_arbiter_pkg::*;
(
    input  logic [3:0] pending_i,
    input  logic [1:0] last_i,
    output logic [1:0] winner_o,
    output logic       valid_o
);

    logic [1:0] cand;

    // Walk from farthest to nearest so the source right after last_i wins.
    always_comb begin
        winner_o = last_i;
        valid_o  = 1'b0;
        cand     = last_i;
        for (int k = 4; k >= 1; k--) begin
            cand = last_i + 2'(k);
            if (pending_i[cand]) begin
                winner_o = cand;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_in_arbiter.sv
// rtl/port_in_arbiter.sv - input-port interrupt arbiter with overrun and timeout tracking
module port_in_arbiter
    import port_in_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       INT_ACK,
    input  logic       READ_STROBE,
    input  logic       CLR_ERR,
    output logic [1:0] SEL,
    output logic       INT,
    output logic [3:0] PENDING,
    output logic [3:0] OVERRUN,
    output logic       TIMEOUT_ERR
);

    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    arb_state_e           state_q;
    logic [1:0]           sel_q;
    logic [1:0]           last_q;
    logic [TMO_CNT_W-1:0] cnt_q;
    logic                 int_q;
    logic [3:0]           pending_q, pending_d;
    logic [3:0]           overrun_q, overrun_d;
    logic                 terr_q, terr_d;

    logic [1:0]           winner;
    logic                 winner_valid;
    logic                 done;
    logic                 tmo_hit;
    logic [3:0]           clr_vec;

    port_in_rr_picker u_picker (
        .pending_i (pending_q),
        .last_i    (last_q),
        .winner_o  (winner),
        .valid_o   (winner_valid)
    );

    // Completion beats a timeout landing on the same edge.
    always_comb begin
        done      = (state_q == ST_WAIT_READ) && READ_STROBE;
        tmo_hit   = (state_q != ST_IDLE) && (cnt_q == TMO_LAST) && !done;
        clr_vec   = done ? (4'b0001 << sel_q) : 4'b0000;
        pending_d = (pending_q & ~clr_vec) | REQ;
        overrun_d = (CLR_ERR ? 4'b0000 : overrun_q) | (REQ & pending_q & ~clr_vec);
        terr_d    = (terr_q & ~CLR_ERR) | tmo_hit;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sel_q     <= SRC_DATA;
            last_q    <= SRC_BCD;
            cnt_q     <= '0;
            int_q     <= 1'b0;
            pending_q <= 4'b0000;
            overrun_q <= 4'b0000;
            terr_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            terr_q    <= terr_d;
            case (state_q)
                ST_IDLE: begin
                    if (winner_valid) begin
                        sel_q   <= winner;
                        cnt_q   <= '0;
                        int_q   <= 1'b1;
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tmo_hit) begin
                        last_q  <= sel_q;
                        int_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (INT_ACK) begin
                            int_q   <= 1'b0;
                            state_q <= ST_WAIT_READ;
                        end
                    end
                end
                ST_WAIT_READ: begin
                    if (done || tmo_hit) begin
                        last_q  <= sel_q;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    int_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SEL         = sel_q;
    assign INT         = int_q;
    assign PENDING     = pending_q;
    assign OVERRUN     = overrun_q;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: doc/port_in_arbiter.md
PORT_IN_ARBITER -- requirements
Module: port_in_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles allowed in WAIT_ACK plus WAIT_READ before the grant is abandoned (range 1..255).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port REQ  input  4  per-source new-data strobes: bit0 DATA, bit1 BYTE0, bit2 BYTE1, bit3 DATA_BCD.
REQ-005 SHALL have port INT_ACK  input  1  CPU interrupt acknowledge.
REQ-006 SHALL have port READ_STROBE  input  1  CPU has read the input port.
REQ-007 SHALL have port CLR_ERR  input  1  clears the sticky error flags.
REQ-008 SHALL have port SEL  output  2  input-mux select: 0 DATA, 1 BYTE0, 2 BYTE1, 3 DATA_BCD.
REQ-009 SHALL have port INT  output  1  CPU interrupt request.
REQ-010 SHALL have port PENDING  output  4  per-source pending flags.
REQ-011 SHALL have port OVERRUN  output  4  sticky per-source overrun flags.
REQ-012 SHALL have port TIMEOUT_ERR  output  1  sticky timeout flag.

Function
REQ-013 SHALL set PENDING[i] at the edge where REQ[i]=1; set SHALL win over a same-cycle clear of the same source.
REQ-014 SHALL set OVERRUN[i] when REQ[i]=1 while PENDING[i]=1 and PENDING[i] is not being cleared in that cycle.
REQ-015 SHALL implement FSM states IDLE, WAIT_ACK, WAIT_READ; all outputs registered.
REQ-016 IDLE: when PENDING is non-zero, SHALL load SEL with the round-robin winner, starting the search at LAST+1 mod 4, then go to WAIT_ACK.
REQ-017 SHALL drive INT=1 in WAIT_ACK only; INT rises one cycle after PENDING is first seen non-zero in IDLE.
REQ-018 WAIT_ACK: INT_ACK=1 SHALL move to WAIT_READ; a READ_STROBE in the same cycle SHALL be ignored.
REQ-019 WAIT_READ: READ_STROBE=1 SHALL clear PENDING[SEL], set LAST=SEL, and return to IDLE.
REQ-020 SHALL ignore INT_ACK outside WAIT_ACK and READ_STROBE outside WAIT_READ.
REQ-021 SHALL hold SEL stable from entry to WAIT_ACK until the return to IDLE; in IDLE, SEL keeps its last value.
REQ-022 SHALL clear an 8-bit timeout counter on entry to WAIT_ACK and increment it each cycle in WAIT_ACK or WAIT_READ.
REQ-023 On timeout (counter reaches TIMEOUT without completion):
- SHALL set TIMEOUT_ERR and set LAST=SEL.
- SHALL leave PENDING[SEL] set.
- SHALL return to IDLE, so the next source is served first.
REQ-024 CLR_ERR SHALL clear OVERRUN and TIMEOUT_ERR; a same-cycle set SHALL win.
REQ-025 Back-to-back service: after a return to IDLE, SHALL re-enter WAIT_ACK on the next edge if PENDING is non-zero (one idle cycle minimum).

Reset
REQ-026 RST SHALL asynchronously force:
- state IDLE, SEL=0, INT=0, PENDING=0, OVERRUN=0, TIMEOUT_ERR=0, counter=0;
- LAST=3, so source 0 has first priority.
REQ-027 A reset asserted mid-grant SHALL discard the grant with no error flagged; after release, only new REQ pulses create pending work.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the source-index constants (SRC_DATA=0, SRC_BYTE0=1, SRC_BYTE1=2, SRC_BCD=3), and the timeout counter width.
REQ-029 The round-robin selection SHALL be a combinational sub-module port_in_rr_picker (inputs: 4-bit pending, 2-bit last; outputs: 2-bit winner, valid).

Verification
REQ-030 After reset, pulse REQ=4'b0100 -> PENDING=4'b0100, then SEL=2 and INT=1; INT_ACK then READ_STROBE -> PENDING=0, INT=0, state IDLE.
REQ-031 REQ=4'b1111 in one cycle, every grant completed promptly -> SEL order 0,1,2,3; then new REQ=4'b0011 with LAST=3 -> order 0,1.
REQ-032 REQ[1] pulsed twice before its READ_STROBE -> OVERRUN=4'b0010; CLR_ERR -> 0; CLR_ERR same cycle as a new overrun -> OVERRUN stays 1.
REQ-033 TIMEOUT=4, grant SEL=0 never acknowledged -> TIMEOUT_ERR=1 four cycles after INT rises, PENDING[0] still 1, next grant SEL=1 when PENDING[1]=1.
REQ-034 RST pulsed in WAIT_READ with SEL=2 -> INT=0, PENDING=0, SEL=0 immediately (before the next clock edge); next REQ=4'b1000 -> SEL=3.
REQ-035 INT_ACK and READ_STROBE high together in WAIT_ACK -> state WAIT_READ, PENDING unchanged; READ_STROBE then required to complete.
